// File: rtl/parking_pkg.sv
// Shared encodings for the parking gate scheduler: FSM states, lane directions, occupancy width.
package parking_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_CLOSING = 2'd2
  } state_t;

  localparam logic DIR_ENTRY = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

  localparam int OCC_W = 4;

endpackage

// File: rtl/gate_timer.sv
// Loadable 32-bit up-counter; o_tc flags the last cycle of the selected window (LIMIT or ALT_LIMIT).
// Load clears the count and latches the limit select; no backpressure, counts every cycle.
module gate_timer #(
  parameter int unsigned LIMIT     = 10,
  parameter int unsigned ALT_LIMIT = 5
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_sel,
  output logic o_tc
);

  localparam logic [31:0] TC_MAIN = 32'(LIMIT - 1);
  localparam logic [31:0] TC_ALT  = 32'(ALT_LIMIT - 1);

  logic [31:0] r_cnt;
  logic        r_sel;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_sel <= 1'b0;
    end else if (i_load) begin
      r_cnt <= '0;
      r_sel <= i_sel;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign o_tc = (r_cnt == (r_sel ? TC_ALT : TC_MAIN));

endmodule

// File: rtl/parking_gate_scheduler.sv
// Arbitrates one barrier gate between entry/exit lanes, times the open/closing windows, tracks occupancy.
// Request pulse to gate_open is 2 cycles; requests are held one-deep per lane, refusals pulse reject.
module parking_gate_scheduler
  import parking_pkg::*;
#(
  parameter int unsigned CLK_F     = 40_000_000,
  parameter int unsigned CAPACITY  = 8,
  parameter int unsigned OPEN_SEC  = 3,
  parameter int unsigned CLOSE_CYC = CLK_F / 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             car_passed,
  output logic             gate_open,
  output logic             gate_dir,
  output logic [OCC_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             reject,
  output logic             timeout
);

  localparam int unsigned      OPEN_CYC = CLK_F * OPEN_SEC;
  localparam logic [OCC_W-1:0] CAP_Q    = OCC_W'(CAPACITY);

  state_t           r_state;
  logic             r_pend_entry;
  logic             r_pend_exit;
  logic             r_last_served;
  logic             r_gate_open;
  logic             r_gate_dir;
  logic             r_reject;
  logic             r_timeout;
  logic [OCC_W-1:0] r_occ;

  logic w_full;
  logic w_empty;
  logic w_grant_entry;
  logic w_grant_exit;
  logic w_tmr_load;
  logic w_tmr_sel;
  logic w_tmr_tc;

  assign w_full  = (r_occ == CAP_Q);
  assign w_empty = (r_occ == '0);

  // Round-robin: with both lanes pending, the lane not served last goes first.
  assign w_grant_exit  = r_pend_exit && (!r_pend_entry || (r_last_served == DIR_ENTRY));
  assign w_grant_entry = r_pend_entry && !w_grant_exit;

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_sel  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((w_grant_entry && !w_full) || (w_grant_exit && !w_empty)) begin
          w_tmr_load = 1'b1;
        end
      end
      ST_OPEN: begin
        if (car_passed || w_tmr_tc) begin
          w_tmr_load = 1'b1;
          w_tmr_sel  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  gate_timer #(
    .LIMIT     (OPEN_CYC),
    .ALT_LIMIT (CLOSE_CYC)
  ) u_timer (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_load (w_tmr_load),
    .i_sel  (w_tmr_sel),
    .o_tc   (w_tmr_tc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= ST_IDLE;
      r_pend_entry  <= 1'b0;
      r_pend_exit   <= 1'b0;
      r_last_served <= DIR_ENTRY;
      r_gate_open   <= 1'b0;
      r_gate_dir    <= DIR_ENTRY;
      r_reject      <= 1'b0;
      r_timeout     <= 1'b0;
      r_occ         <= '0;
    end else begin
      r_reject  <= (entry_req && w_full) || (exit_req && w_empty);
      r_timeout <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_grant_exit) begin
            r_pend_exit <= 1'b0;
            if (w_empty) begin
              r_reject <= 1'b1;
            end else begin
              r_gate_dir    <= DIR_EXIT;
              r_last_served <= DIR_EXIT;
              r_gate_open   <= 1'b1;
              r_state       <= ST_OPEN;
            end
          end else if (w_grant_entry) begin
            r_pend_entry <= 1'b0;
            if (w_full) begin
              r_reject <= 1'b1;
            end else begin
              r_gate_dir    <= DIR_ENTRY;
              r_last_served <= DIR_ENTRY;
              r_gate_open   <= 1'b1;
              r_state       <= ST_OPEN;
            end
          end
        end
        ST_OPEN: begin
          if (car_passed) begin
            if (r_gate_dir == DIR_ENTRY && !w_full) begin
              r_occ <= r_occ + 1'b1;
            end else if (r_gate_dir == DIR_EXIT && !w_empty) begin
              r_occ <= r_occ - 1'b1;
            end
            r_gate_open <= 1'b0;
            r_state     <= ST_CLOSING;
          end else if (w_tmr_tc) begin
            r_timeout   <= 1'b1;
            r_gate_open <= 1'b0;
            r_state     <= ST_CLOSING;
          end
        end
        ST_CLOSING: begin
          if (w_tmr_tc) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Capture after dispatch so a fresh request in the grant cycle is not lost.
      if (entry_req && !w_full) begin
        r_pend_entry <= 1'b1;
      end
      if (exit_req && !w_empty) begin
        r_pend_exit <= 1'b1;
      end
    end
  end

  assign gate_open = r_gate_open;
  assign gate_dir  = r_gate_dir;
  assign occupancy = r_occ;
  assign full      = w_full;
  assign empty     = w_empty;
  assign reject    = r_reject;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Directed bench for parking_gate_scheduler: OPEN_CYC=10, CLOSE_CYC=5, CAPACITY=2.
module tb_parking_gate_scheduler;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic       car_passed = 1'b0;
  logic       gate_open;
  logic       gate_dir;
  logic [3:0] occupancy;
  logic       full;
  logic       empty;
  logic       reject;
  logic       timeout;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  parking_gate_scheduler #(
    .CLK_F     (10),
    .CAPACITY  (2),
    .OPEN_SEC  (1),
    .CLOSE_CYC (5)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .entry_req  (entry_req),
    .exit_req   (exit_req),
    .car_passed (car_passed),
    .gate_open  (gate_open),
    .gate_dir   (gate_dir),
    .occupancy  (occupancy),
    .full       (full),
    .empty      (empty),
    .reject     (reject),
    .timeout    (timeout)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Request a lane, let one car through on the first open cycle, then wait out CLOSING.
  task automatic run_car(input logic is_exit);
    int w;
    if (is_exit) exit_req = 1'b1; else entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    exit_req  = 1'b0;
    w = 0;
    while (!gate_open && w < 20) begin
      step();
      w++;
    end
    checks++;
    if (gate_open !== 1'b1) begin
      failures++;
      $display("FAIL run_car_open got=%0b exp=1 dir=%0b", gate_open, is_exit);
    end
    car_passed = 1'b1;
    step();
    car_passed = 1'b0;
    repeat (6) step();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    checks++; if (gate_open !== 1'b0) begin failures++; $display("FAIL reset_gate_open got=%0b exp=0", gate_open); end
    checks++; if (gate_dir !== 1'b0) begin failures++; $display("FAIL reset_gate_dir got=%0b exp=0", gate_dir); end
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
    checks++; if (reject !== 1'b0) begin failures++; $display("FAIL reset_reject got=%0b exp=0", reject); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%0b exp=0", timeout); end
  endtask

  task automatic test_basic_entry();
    int n;
    int lo;
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    checks++; if (gate_open !== 1'b0) begin failures++; $display("FAIL entry_capture_cycle got=%0b exp=0", gate_open); end
    step();
    checks++; if (gate_open !== 1'b1) begin failures++; $display("FAIL entry_latency got=%0b exp=1", gate_open); end
    checks++; if (gate_dir !== 1'b0) begin failures++; $display("FAIL entry_dir got=%0b exp=0", gate_dir); end
    n = gate_open ? 1 : 0;
    step(); if (gate_open) n++;
    step(); if (gate_open) n++;
    car_passed = 1'b1;
    step();
    car_passed = 1'b0;
    checks++; if (n !== 3) begin failures++; $display("FAIL entry_open_cycles got=%0d exp=3", n); end
    checks++; if (gate_open !== 1'b0) begin failures++; $display("FAIL entry_close got=%0b exp=0", gate_open); end
    checks++; if (occupancy !== 4'd1) begin failures++; $display("FAIL entry_occupancy got=%0d exp=1", occupancy); end
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL entry_empty got=%0b exp=0", empty); end
    lo = 0;
    repeat (5) begin
      if (!gate_open) lo++;
      step();
    end
    checks++; if (lo !== 5) begin failures++; $display("FAIL entry_closing_low got=%0d exp=5", lo); end
  endtask

  task automatic test_simultaneous();
    int gap;
    entry_req = 1'b1;
    exit_req  = 1'b1;
    step();
    entry_req = 1'b0;
    exit_req  = 1'b0;
    step();
    checks++; if (gate_open !== 1'b1) begin failures++; $display("FAIL simul_first_open got=%0b exp=1", gate_open); end
    checks++; if (gate_dir !== 1'b1) begin failures++; $display("FAIL simul_first_dir got=%0b exp=1", gate_dir); end
    car_passed = 1'b1;
    step();
    car_passed = 1'b0;
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL simul_mid_occupancy got=%0d exp=0", occupancy); end
    gap = 0;
    while (!gate_open && gap < 30) begin
      gap++;
      step();
    end
    checks++; if (gap !== 6) begin failures++; $display("FAIL simul_gap got=%0d exp=6", gap); end
    checks++; if (gate_dir !== 1'b0) begin failures++; $display("FAIL simul_second_dir got=%0b exp=0", gate_dir); end
    car_passed = 1'b1;
    step();
    car_passed = 1'b0;
    checks++; if (occupancy !== 4'd1) begin failures++; $display("FAIL simul_net_occupancy got=%0d exp=1", occupancy); end
    repeat (6) step();
  endtask

  task automatic test_timeout();
    int n;
    int to;
    exit_req = 1'b1;
    step();
    exit_req = 1'b0;
    step();
    checks++; if (gate_dir !== 1'b1) begin failures++; $display("FAIL timeout_dir got=%0b exp=1", gate_dir); end
    n = 0;
    to = 0;
    while (gate_open && n < 40) begin
      n++;
      if (timeout) to++;
      step();
    end
    checks++; if (n !== 10) begin failures++; $display("FAIL timeout_open_cycles got=%0d exp=10", n); end
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL timeout_pulse_cycle got=%0b exp=1", timeout); end
    repeat (8) begin
      if (timeout) to++;
      step();
    end
    checks++; if (to !== 1) begin failures++; $display("FAIL timeout_pulse_count got=%0d exp=1", to); end
    checks++; if (occupancy !== 4'd1) begin failures++; $display("FAIL timeout_occupancy got=%0d exp=1", occupancy); end
  endtask

  task automatic test_full_empty_refusal();
    int opens;
    run_car(1'b0);
    checks++; if (occupancy !== 4'd2) begin failures++; $display("FAIL fill_occupancy got=%0d exp=2", occupancy); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%0b exp=1", full); end
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    checks++; if (reject !== 1'b1) begin failures++; $display("FAIL full_reject got=%0b exp=1", reject); end
    step();
    checks++; if (reject !== 1'b0) begin failures++; $display("FAIL full_reject_width got=%0b exp=0", reject); end
    opens = 0;
    repeat (12) begin
      if (gate_open) opens++;
      step();
    end
    checks++; if (opens !== 0) begin failures++; $display("FAIL full_gate_closed got=%0d exp=0", opens); end
    run_car(1'b1);
    run_car(1'b1);
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%0b exp=1", empty); end
    exit_req = 1'b1;
    step();
    exit_req = 1'b0;
    checks++; if (reject !== 1'b1) begin failures++; $display("FAIL empty_reject got=%0b exp=1", reject); end
    step();
    checks++; if (reject !== 1'b0) begin failures++; $display("FAIL empty_reject_width got=%0b exp=0", reject); end
    opens = 0;
    repeat (12) begin
      if (gate_open) opens++;
      step();
    end
    checks++; if (opens !== 0) begin failures++; $display("FAIL empty_gate_closed got=%0d exp=0", opens); end
  endtask

  task automatic test_mid_reset();
    int opens;
    int tos;
    run_car(1'b0);
    exit_req = 1'b1;
    step();
    exit_req = 1'b0;
    step();
    checks++; if (gate_open !== 1'b1) begin failures++; $display("FAIL midrst_open got=%0b exp=1", gate_open); end
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    checks++; if (gate_open !== 1'b0) begin failures++; $display("FAIL midrst_gate got=%0b exp=0", gate_open); end
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL midrst_occupancy got=%0d exp=0", occupancy); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL midrst_empty got=%0b exp=1", empty); end
    checks++; if (gate_dir !== 1'b0) begin failures++; $display("FAIL midrst_dir got=%0b exp=0", gate_dir); end
    opens = 0;
    tos = 0;
    repeat (20) begin
      if (gate_open) opens++;
      if (timeout) tos++;
      step();
    end
    checks++; if (opens !== 0) begin failures++; $display("FAIL midrst_pending_cleared got=%0d exp=0", opens); end
    checks++; if (tos !== 0) begin failures++; $display("FAIL midrst_no_timeout got=%0d exp=0", tos); end
  endtask

  initial begin
    test_reset();
    test_basic_entry();
    test_simultaneous();
    test_timeout();
    test_full_empty_refusal();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/parking_gate_scheduler.md
Name: parking_gate_scheduler

Overview:
Shares a single barrier gate between the entry lane and the exit lane of the parking lot. Consumes one-cycle pulses from upstream debouncers (entry button, exit button, car-passed sensor). Grants the gate to one lane at a time, times the open window, and maintains the occupancy count with full/empty flags. Sits between the debouncer instances and the gate actuator/display logic.

Parameters:
CLK_F, 40_000_000, clock frequency in Hz
CAPACITY, 8, number of spaces; range 1..15
OPEN_SEC, 3, gate open window in seconds; OPEN_CYC = CLK_F*OPEN_SEC
CLOSE_CYC, CLK_F/2, closing guard time in cycles

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous, active-high reset
entry_req  input  1  one-cycle pulse, entry button (debounced)
exit_req  input  1  one-cycle pulse, exit button (debounced)
car_passed  input  1  one-cycle pulse, pass sensor (debounced)
gate_open  output  1  gate actuator command, 1 = open
gate_dir  output  1  lane owning the gate: 0 = entry, 1 = exit
occupancy  output  4  cars currently inside, 0..CAPACITY
full  output  1  occupancy == CAPACITY
empty  output  1  occupancy == 0
reject  output  1  one-cycle pulse: entry refused (full) or exit refused (empty)
timeout  output  1  one-cycle pulse: open window expired without car_passed

Behaviour:
- Reset (RST=1 at a CLK edge): state IDLE; gate_open=0, gate_dir=0, occupancy=0, full=0, empty=1, reject=0, timeout=0; pending flags cleared; timer cleared; last_served=entry. Reset mid-operation closes the gate on the next edge and discards all pending requests.
- All outputs registered. full/empty derived from the registered occupancy (valid in the same cycle as occupancy).
- Request capture, every cycle in every state: entry_req sets pend_entry when not full; if full, no latch and reject pulses next cycle. exit_req sets pend_exit when not empty; if empty, reject pulses. A repeated request while already pending is absorbed (one pending per lane). A same-cycle entry_req and exit_req both latch; a same-cycle double refusal produces one reject pulse.
- States: IDLE, OPEN, CLOSING.
- IDLE: if one flag pending, grant that lane. If both pending, grant the lane opposite last_served (round-robin; exit wins first after reset). Grant cycle: clear that pending flag, set gate_dir, set last_served, load timer, go OPEN. gate_open=1 from the next cycle (request pulse at cycle N in idle -> gate_open high at N+2, since capture happens at N+1).
- Dispatch re-check: an entry grant when full at dispatch is dropped with a reject pulse and no state change. Likewise an exit grant when empty. Re-arbitration happens next cycle.
- OPEN: timer counts 0..OPEN_CYC-1.
  - car_passed: occupancy +1 (dir 0) or -1 (dir 1) next cycle; go CLOSING.
  - Timer terminal without car_passed: timeout pulse; occupancy unchanged; go CLOSING.
  - car_passed on the terminal cycle counts as passed, with no timeout.
- CLOSING: gate_open=0 for exactly CLOSE_CYC cycles, then IDLE. car_passed outside OPEN is ignored.
- Occupancy never wraps: saturates at 0 and CAPACITY, which the dispatch check guarantees.
- Timer is 32 bits, cleared on every load.

Decomposition:
- Shared package parking_pkg: state encoding (IDLE/OPEN/CLOSING), DIR_ENTRY=0 and DIR_EXIT=1 constants, occupancy width constant 4.
- One sub-module, gate_timer: loadable up-counter with terminal-count flag (parameter LIMIT). Instantiated once for OPEN_CYC; the CLOSING count reuses it with LIMIT reloaded via a select input.

Test Plan:
All scenarios use CLK_F=10, OPEN_SEC=1 (OPEN_CYC=10), CLOSE_CYC=5, CAPACITY=2.
- Reset state: RST high 2 cycles -> gate_open=0, occupancy=0, empty=1, full=0, reject=0.
- Basic entry: entry_req pulse, car_passed 3 cycles after gate_open rises -> gate_open high 3 cycles, gate_dir=0, occupancy=1, gate low 5 cycles, then IDLE.
- Timeout: exit_req with occupancy=1, no car_passed -> gate_open high exactly 10 cycles, timeout pulses once, occupancy stays 1.
- Simultaneous requests: occupancy=1, entry_req and exit_req same cycle -> exit served first (gate_dir=1), entry served after CLOSING (gate_dir=0), net occupancy 1.
- Full/empty refusal: fill to 2, then entry_req -> reject one cycle, gate stays closed. From 0, exit_req -> reject, gate stays closed.
- Mid-operation reset: RST during OPEN with occupancy=1 -> next cycle gate_open=0, occupancy=0, pending cleared, no timeout pulse.
